pc_src_sequencer: RTL

Multicycle PC-update and exception sequencer for the CPU datapath. Drives the select and write enables of the PC source mux (PCSourceCtrl: 0=Exception_Destiny, 1=EPC_Out, 2=ALU_Out, 3=Shift_Left_2), plus PCWrite and EPCWrite. Handles the full exception entry: save EPC, read the handler vector byte from memory, and load it into the PC. Sits between the main control FSM and the PC/EPC registers.

---
 rtl/pc_src_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pc_src_sequencer.sv
// Multicycle PC-update / exception-entry sequencer driving the PC source mux, PC and EPC write enables.
// Optional `PC_RFE_CHECK_EN: a return-from-exception outside a handler is trapped as a cause-0 exception.
module pc_src_sequencer #(
   parameter logic [7:0]  VEC_BASE = 8'd253,
   parameter int unsigned MEM_LAT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_req,
   input  logic [1:0]  pc_req_type,
   input  logic        exc_valid,
   input  logic [1:0]  exc_cause,
   input  logic [7:0]  vec_data,
   output logic [1:0]  PCSourceCtrl,
   output logic        PCWrite,
   output logic        EPCWrite,
   output logic        vec_rd,
   output logic [7:0]  vec_addr,
   output logic [31:0] exc_destiny,
   output logic        busy,
   output logic        done,
   output logic        in_handler
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      PC_WR,
      EPC_SAVE,
      VEC_RD,
      VEC_WAIT,
      EXC_WR
   } state_t;

   state_t             state;
   logic [1:0]         cause;
   logic [CNT_W-1:0]   cnt;

   // Request type to mux select: sequential/branch take ALU_Out, jump takes Shift_Left_2, rfe takes EPC_Out.
   function automatic logic [1:0] src_of(input logic [1:0] t);
      logic [1:0] s;
      case (t)
         2'd0, 2'd1: s = 2'd2;
         2'd2:       s = 2'd3;
         default:    s = 2'd1;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cause        <= 2'd0;
         cnt          <= '0;
         PCSourceCtrl <= 2'd2;
         PCWrite      <= 1'b0;
         EPCWrite     <= 1'b0;
         vec_rd       <= 1'b0;
         vec_addr     <= 8'd0;
         exc_destiny  <= 32'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         in_handler   <= 1'b0;
      end else begin
         PCWrite  <= 1'b0;
         EPCWrite <= 1'b0;
         vec_rd   <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (exc_valid) begin
                  cause    <= (exc_cause == 2'd3) ? 2'd0 : exc_cause;
                  state    <= EPC_SAVE;
                  EPCWrite <= 1'b1;
                  busy     <= 1'b1;
               end else if (pc_req) begin
`ifdef PC_RFE_CHECK_EN
                  if (pc_req_type == 2'd3 && !in_handler) begin
                     cause    <= 2'd0;
                     state    <= EPC_SAVE;
                     EPCWrite <= 1'b1;
                     busy     <= 1'b1;
                  end else
`endif
                  begin
                     state        <= PC_WR;
                     PCWrite      <= 1'b1;
                     done         <= 1'b1;
                     busy         <= 1'b1;
                     PCSourceCtrl <= src_of(pc_req_type);
                     if (pc_req_type == 2'd3) in_handler <= 1'b0;
                  end
               end
            end
            PC_WR: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            EPC_SAVE: begin
               state    <= VEC_RD;
               vec_rd   <= 1'b1;
               vec_addr <= VEC_BASE + {6'd0, cause};
            end
            VEC_RD: begin
               state <= VEC_WAIT;
               cnt   <= CNT_W'(MEM_LAT);
            end
            // Capture the vector on the edge that closes the final wait cycle.
            VEC_WAIT: begin
               if (cnt == CNT_W'(1)) begin
                  exc_destiny  <= {24'd0, vec_data};
                  state        <= EXC_WR;
                  PCWrite      <= 1'b1;
                  done         <= 1'b1;
                  PCSourceCtrl <= 2'd0;
                  in_handler   <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            EXC_WR: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
